// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised up/down modulo counter with count enable,
// synchronous clear, clamped parallel load and a registered terminal-count pulse.
// Latency: one clock from sampled inputs to q/tc; zero is combinational on q.
// Backpressure: none, since the counter accepts a command on every edge.
//
// Parameters:
//   WIDTH  counter width in bits (2..32)
//   MAX    terminal value (1..2**WIDTH-1); the count range is 0..MAX
// Ports:
//   clk    in   rising-edge clock
//   clr_n  in   asynchronous active-low reset
//   sclr   in   synchronous clear (highest priority)
//   load   in   synchronous parallel load of din, clamped to MAX
//   din    in   load value
//   en     in   count enable
//   up     in   direction: 1 up, 0 down
//   q      out  registered count
//   tc     out  registered terminal-count pulse
//   zero   out  combinational q == 0
//
// Build option: define UPDOWN_COUNTER_SAT_EN for saturating mode. In that mode
// the counter pins at the limit instead of wrapping, and tc stays high on every
// enabled cycle spent at the limit. Without the macro the counter wraps modulo MAX+1.

module updown_counter_mod #(
  parameter int unsigned          WIDTH = 4,
  parameter logic [WIDTH-1:0]     MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero
);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_tc_nxt;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_q == MAX);
  assign w_at_zero = (r_q == '0);

  // Next-state selection in priority order: sclr > load > en > hold.
  // The increment is only taken below MAX and the decrement only above zero,
  // so neither ever leaves the WIDTH-bit range.
  always_comb begin
    w_q_nxt  = r_q;
    w_tc_nxt = 1'b0;
    if (sclr) begin
      w_q_nxt = '0;
    end else if (load) begin
      w_q_nxt = (din > MAX) ? MAX : din;
    end else if (en) begin
      if (up) begin
        if (w_at_max) begin
`ifdef UPDOWN_COUNTER_SAT_EN
          w_q_nxt  = MAX;
`else
          w_q_nxt  = '0;
`endif
          w_tc_nxt = 1'b1;
        end else begin
          w_q_nxt = r_q + WIDTH'(1);
        end
      end else begin
        if (w_at_zero) begin
`ifdef UPDOWN_COUNTER_SAT_EN
          w_q_nxt  = '0;
`else
          w_q_nxt  = MAX;
`endif
          w_tc_nxt = 1'b1;
        end else begin
          w_q_nxt = r_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q  <= '0;
      r_tc <= 1'b0;
    end else begin
      r_q  <= w_q_nxt;
      r_tc <= w_tc_nxt;
    end
  end

  assign q    = r_q;
  assign tc   = r_tc;
  assign zero = w_at_zero;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Testbench for updown_counter_mod (WIDTH=4, MAX=9). The stimulus driver pushes
// the reference-model expectation for each issued command into a queue. An
// independent monitor pops and compares after each rising edge.

module tb_updown_counter_mod;

  localparam int W   = 4;
  localparam int MAX = 9;

  typedef struct {
    int q;
    bit tc;
  } exp_t;

  logic         clk;
  logic         clr_n;
  logic         sclr;
  logic         load;
  logic [W-1:0] din;
  logic         en;
  logic         up;
  logic [W-1:0] q;
  logic         tc;
  logic         zero;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   m_q = 0;   // reference count value

  updown_counter_mod #(.WIDTH(W), .MAX(4'(MAX))) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .sclr  (sclr),
    .load  (load),
    .din   (din),
    .en    (en),
    .up    (up),
    .q     (q),
    .tc    (tc),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: after every rising edge, compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("q", int'(q), e.q);
      check("tc", int'(tc), int'(e.tc));
      check("zero", int'(zero), int'(e.q == 0));
    end
  end

  // Reference model from the counting rules, expressed as modulo arithmetic.
  task automatic step(input bit s, input bit l, input int d, input bit e, input bit u);
    exp_t x;
    @(negedge clk);
    sclr = s; load = l; din = W'(d); en = e; up = u;
    x.tc = 1'b0;
    if (s) begin
      x.q = 0;
    end else if (l) begin
      x.q = (d > MAX) ? MAX : d;
    end else if (e) begin
      if (u) begin
        x.tc = (m_q == MAX);
`ifdef UPDOWN_COUNTER_SAT_EN
        x.q  = (m_q == MAX) ? MAX : m_q + 1;
`else
        x.q  = (m_q + 1) % (MAX + 1);
`endif
      end else begin
        x.tc = (m_q == 0);
`ifdef UPDOWN_COUNTER_SAT_EN
        x.q  = (m_q == 0) ? 0 : m_q - 1;
`else
        x.q  = (m_q + MAX) % (MAX + 1);
`endif
      end
    end else begin
      x.q = m_q;
    end
    m_q = x.q;
    sb.push_back(x);
  endtask

  task automatic idle_inputs();
    sclr = 1'b0; load = 1'b0; din = '0; en = 1'b0; up = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0;
    idle_inputs();
    #12;
    check("reset_q", int'(q), 0);
    check("reset_tc", int'(tc), 0);
    check("reset_zero", int'(zero), 1);
    @(negedge clk);
    clr_n = 1'b1;
    m_q = 0;

    // Up wrap: 22 enabled-up cycles cover more than two modulo-10 periods.
    for (int i = 0; i < 22; i++) step(0, 0, 0, 1, 1);
    // Down wrap from a loaded 2.
    step(0, 1, 2, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    // Load clamp, sclr over load, load over counting at terminal.
    step(0, 1, 12, 0, 0);
    step(1, 1, 5, 1, 1);
    step(0, 1, 9, 0, 0);
    step(0, 1, 5, 1, 1);
    // Hold for four cycles.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, (i % 2) == 0);
    // Direction toggling from 4.
    step(0, 1, 4, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, (i % 2) == 0);
    // Approach the limits (saturating behaviour when that build is selected).
    step(0, 1, 8, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0);
    drain();

    // Asynchronous reset mid-count at q = 7, asserted away from any edge.
    step(0, 1, 7, 0, 0);
    drain();
    @(negedge clk);
    idle_inputs();
    #2;
    clr_n = 1'b0;
    #1;
    check("arst_q", int'(q), 0);
    check("arst_tc", int'(tc), 0);
    check("arst_zero", int'(zero), 1);
    @(negedge clk);
    clr_n = 1'b1;
    m_q = 0;
    step(0, 0, 0, 1, 1);

    // Randomized traffic, biased toward counting.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r < 3, (r >= 3 && r < 10) || (r < 2), $urandom_range(0, 15),
           r >= 20 || (r < 6 && $urandom_range(0, 1) == 1), $urandom_range(0, 3) != 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
